// File: rtl/prio_encoder_pipe_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
// Mode selection values and the index-width helper used by every module.
package prio_encoder_pipe_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   function automatic int clog2_f(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_encoder_pipe_search.sv
// Combinational search: first set bit of req at or above start, wrapping to bit 0.
// none is raised when req is all-zero; idx is then 0.
module prio_search
   import prio_encoder_pipe_pkg::*;
#(
   parameter int N = 4,
   parameter int W = clog2_f(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         none
);

   logic [W-1:0] hi_idx;
   logic [W-1:0] lo_idx;
   logic         hi_hit;

   // Descending scans: the last hit written is the lowest matching index.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      hi_hit = 1'b0;
      for (int j = N - 1; j >= 0; j--) begin
         if (req[j]) begin
            lo_idx = W'(j);
            if (j >= int'(start)) begin
               hi_idx = W'(j);
               hi_hit = 1'b1;
            end
         end
      end
   end

   assign none = ~|req;
   assign idx  = hi_hit ? hi_idx : lo_idx;

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides.
// Fixed mode: highest index wins. Round-robin mode: search starts after ptr.
module prio_encoder_pipe
   import prio_encoder_pipe_pkg::*;
#(
   parameter int N       = 4,
   parameter int W       = clog2_f(N),
   parameter int RR_MODE = MODE_FIXED
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] req,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_none
);

   logic [N-1:0] search_req;
   logic [W-1:0] search_start;
   logic [W-1:0] found_idx;
   logic [W-1:0] win_idx;
   logic [W-1:0] ptr;
   logic         found_none;
   logic         accept;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Fixed mode reuses the ascending search on the bit-reversed vector.
   always_comb begin
      search_req   = req;
      search_start = '0;
      if (RR_MODE == MODE_RR) begin
         search_start = (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;
      end else begin
         for (int i = 0; i < N; i++) begin
            search_req[i] = req[N-1-i];
         end
      end
   end

   prio_search #(
      .N (N),
      .W (W)
   ) u_search (
      .req   (search_req),
      .start (search_start),
      .idx   (found_idx),
      .none  (found_none)
   );

   assign win_idx = (RR_MODE == MODE_RR) ? found_idx : W'(N - 1) - found_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_none  <= 1'b0;
         ptr       <= W'(N - 1);
      end else if (accept) begin
         out_valid <= 1'b1;
         out_idx   <= found_none ? '0 : win_idx;
         out_none  <= found_none;
         if (RR_MODE == MODE_RR && !found_none) begin
            ptr <= win_idx;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
